// File: rtl/mha_pkg.sv
// Shared types and constants for the MHA datapath blocks.
package mha_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } acc_state_t;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/sat_trunc.sv
// Narrows the wide signed accumulator to a 16-bit result.
// ACC_SAT_EN defined: clamp to the 16-bit signed range; otherwise two's-complement wrap.
module sat_trunc
  import mha_pkg::*;
#(
  parameter int ACC_W = 22
) (
  input  logic [ACC_W-1:0]  acc_in,
  output logic [DATA_W-1:0] sum_out
);

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_W = ACC_W'($signed(SAT_MAX));
  localparam logic signed [ACC_W-1:0] MIN_W = ACC_W'($signed(SAT_MIN));

  always_comb begin
    sum_out = acc_in[DATA_W-1:0];
    if ($signed(acc_in) > MAX_W) begin
      sum_out = SAT_MAX;
    end else if ($signed(acc_in) < MIN_W) begin
      sum_out = SAT_MIN;
    end
  end
`else
  logic unused_acc_bits;

  assign sum_out         = acc_in[DATA_W-1:0];
  assign unused_acc_bits = ^acc_in;
`endif

endmodule

// File: rtl/dot_accumulator_16.sv
// Sums VEC_LEN signed 16-bit products into one dot-product result with valid/ready output.
// Result formatting selected by ACC_SAT_EN (see sat_trunc).
//
// state | meaning
// S_ACC | collecting products, O_RDY high
// S_OUT | result pending on O_SUM/O_VLD, incoming products dropped
module dot_accumulator_16
  import mha_pkg::*;
#(
  parameter int VEC_LEN = 64
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VLD,
  input  logic [DATA_W-1:0] I_PRODUCT,
  input  logic              I_CLR,
  output logic              O_RDY,
  output logic              O_VLD,
  input  logic              I_RDY,
  output logic [DATA_W-1:0] O_SUM,
  output logic              O_DROP
);

  localparam int CNT_W = $clog2(VEC_LEN) + 1;
  localparam int ACC_W = DATA_W + $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  acc_state_t              state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n, acc_sum;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    vld_q, vld_n;
  logic                    drop_q, drop_n;
  logic [DATA_W-1:0]       sum_q, sum_n, fmt_sum;

  assign acc_sum = acc + ACC_W'($signed(I_PRODUCT));

  sat_trunc #(.ACC_W(ACC_W)) u_fmt (
    .acc_in  (acc_sum),
    .sum_out (fmt_sum)
  );

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state  <= S_ACC;
      acc    <= '0;
      cnt    <= '0;
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
      sum_q  <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      vld_q  <= vld_n;
      drop_q <= drop_n;
      sum_q  <= sum_n;
    end
  end

  // Clear wins over everything and swallows a same-cycle product without flagging a drop.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    vld_n   = vld_q;
    drop_n  = drop_q;
    sum_n   = sum_q;
    if (I_CLR) begin
      state_n = S_ACC;
      acc_n   = '0;
      cnt_n   = '0;
      vld_n   = 1'b0;
      drop_n  = 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (I_VLD) begin
            if (cnt == LAST_CNT) begin
              sum_n   = fmt_sum;
              vld_n   = 1'b1;
              acc_n   = '0;
              cnt_n   = '0;
              state_n = S_OUT;
            end else begin
              acc_n = acc_sum;
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (I_VLD) begin
            drop_n = 1'b1;
          end
          if (I_RDY) begin
            vld_n   = 1'b0;
            state_n = S_ACC;
          end
        end
        default: state_n = S_ACC;
      endcase
    end
  end

  assign O_RDY  = (state == S_ACC);
  assign O_VLD  = vld_q;
  assign O_SUM  = sum_q;
  assign O_DROP = drop_q;

endmodule

// File: tb/tb_dot_accumulator_16.sv
// Bench for dot_accumulator_16: table vectors with a result scoreboard plus hand-written corner sequences.
module tb_dot_accumulator_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vld = 1'b0, i_clr = 1'b0, i_rdy = 1'b1;
  logic [15:0] i_prod = '0;
  logic        o_rdy, o_vld, o_drop;
  logic [15:0] o_sum;

  logic        v1_vld = 1'b0;
  logic [15:0] v1_prod = '0;
  logic        v1_o_rdy, v1_o_vld, v1_o_drop;
  logic [15:0] v1_o_sum;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  dot_accumulator_16 #(.VEC_LEN(4)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(i_vld), .I_PRODUCT(i_prod), .I_CLR(i_clr),
    .O_RDY(o_rdy), .O_VLD(o_vld), .I_RDY(i_rdy), .O_SUM(o_sum), .O_DROP(o_drop)
  );

  dot_accumulator_16 #(.VEC_LEN(1)) dut1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(v1_vld), .I_PRODUCT(v1_prod), .I_CLR(1'b0),
    .O_RDY(v1_o_rdy), .O_VLD(v1_o_vld), .I_RDY(1'b1), .O_SUM(v1_o_sum), .O_DROP(v1_o_drop)
  );

  typedef struct packed {
    logic [3:0][15:0] p;
    logic [15:0]      exp_sat;
    logic [15:0]      exp_wrap;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Handshake completes on the next edge; the popped expectation must match the held sum.
  always @(negedge clk) begin
    if (o_vld && i_rdy) begin
      if (sb.size() == 0) chk("sb_unexpected_result", o_sum, 16'hDEAD);
      else chk("sb_sum", o_sum, sb.pop_front());
    end
  end

  task automatic send(input logic [15:0] p);
    int w;
    w = 0;
    while (!o_rdy && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!o_rdy) chk("rdy_timeout", o_rdy, 1);
    i_vld  = 1'b1;
    i_prod = p;
    @(posedge clk); #1;
    i_vld  = 1'b0;
  endtask

  task automatic send4(input logic [15:0] a, b, c, d, input logic [15:0] e, input logic push);
    send(a); send(b); send(c);
    if (push) sb.push_back(e);
    send(d);
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, d, es, ew);
    vec_t v;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.exp_sat = es; v.exp_wrap = ew;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(16'd3, 16'hFFFB, 16'd7, 16'd10, 16'h000F, 16'h000F);
    vecs[1] = mk(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 16'hC000);
    vecs[2] = mk(16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h8000, 16'h4000);
    vecs[3] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000);
    vecs[4] = mk(16'd1, 16'd1, 16'd1, 16'd1, 16'h0004, 16'h0004);
    vecs[5] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFC, 16'hFFFC);
    vecs[6] = mk(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'hFFFE, 16'hFFFE);
    vecs[7] = mk(16'h7FFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h7FFF);
    vecs[8] = mk(16'h8000, 16'hFFFF, 16'h0001, 16'h0000, 16'h8000, 16'h8000);
    vecs[9] = mk(16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF);

    #1;
    chk("rst_o_rdy", o_rdy, 1);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o_sum", o_sum, 0);
    chk("rst_o_drop", o_drop, 0);
    chk("rst_v1_o_rdy", v1_o_rdy, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
`ifdef ACC_SAT_EN
      send4(vecs[i].p[0], vecs[i].p[1], vecs[i].p[2], vecs[i].p[3], vecs[i].exp_sat, 1'b1);
`else
      send4(vecs[i].p[0], vecs[i].p[1], vecs[i].p[2], vecs[i].p[3], vecs[i].exp_wrap, 1'b1);
`endif
      chk("lat_vld_high", o_vld, 1);
      chk("lat_rdy_low", o_rdy, 0);
      @(posedge clk); #1;
      chk("vld_one_cycle", o_vld, 0);
      chk("rdy_back", o_rdy, 1);
    end

    // Stall with a dropped product.
    i_rdy = 1'b0;
    send4(16'd2, 16'd2, 16'd2, 16'd2, 16'h0008, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        i_vld  = 1'b1;
        i_prod = 16'd77;
      end
      @(posedge clk); #1;
      i_vld = 1'b0;
      chk("stall_vld", o_vld, 1);
      chk("stall_sum", o_sum, 16'h0008);
      chk("stall_rdy", o_rdy, 0);
    end
    chk("stall_drop", o_drop, 1);
    i_rdy = 1'b1;
    @(posedge clk); #1;
    chk("post_stall_vld", o_vld, 0);
    chk("post_stall_rdy", o_rdy, 1);
    chk("drop_sticky", o_drop, 1);
    send4(16'd3, 16'hFFFB, 16'd7, 16'd10, 16'h000F, 1'b1);
    @(posedge clk); #1;

    // Clear mid-vector with a simultaneous product.
    send(16'd5); send(16'd6);
    i_clr = 1'b1; i_vld = 1'b1; i_prod = 16'd9;
    @(posedge clk); #1;
    i_clr = 1'b0; i_vld = 1'b0;
    chk("clr_drop", o_drop, 0);
    chk("clr_rdy", o_rdy, 1);
    chk("clr_vld", o_vld, 0);
    send4(16'd1, 16'd1, 16'd1, 16'd1, 16'h0004, 1'b1);
    chk("clr_vec_vld", o_vld, 1);
    chk("clr_vec_drop", o_drop, 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-vector.
    send(16'd5); send(16'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_sum", o_sum, 0);
    chk("arst_mid_rdy", o_rdy, 1);
    chk("arst_mid_vld", o_vld, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send4(16'd10, 16'd20, 16'd30, 16'hFFFB, 16'h0037, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset with a result pending.
    i_rdy = 1'b0;
    send4(16'd100, 16'd200, 16'd300, 16'd400, 16'h03E8, 1'b0);
    i_vld = 1'b1; i_prod = 16'd1;
    @(posedge clk); #1;
    i_vld = 1'b0;
    chk("pend_vld", o_vld, 1);
    chk("pend_sum", o_sum, 16'h03E8);
    chk("pend_drop", o_drop, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pend_vld", o_vld, 0);
    chk("arst_pend_sum", o_sum, 0);
    chk("arst_pend_drop", o_drop, 0);
    chk("arst_pend_rdy", o_rdy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_rdy = 1'b1;
    send4(16'd10, 16'd20, 16'd30, 16'hFFFB, 16'h0037, 1'b1);
    @(posedge clk); #1;

    // VEC_LEN = 1 instance.
    v1_vld = 1'b1; v1_prod = 16'hFFFF;
    @(posedge clk); #1;
    v1_vld = 1'b0;
    chk("v1_first_vld", v1_o_vld, 1);
    chk("v1_first_sum", v1_o_sum, 16'hFFFF);
    chk("v1_first_rdy", v1_o_rdy, 0);
    @(posedge clk); #1;
    chk("v1_rdy_back", v1_o_rdy, 1);
    chk("v1_vld_drop", v1_o_vld, 0);
    v1_vld = 1'b1; v1_prod = 16'd2;
    @(posedge clk); #1;
    v1_vld = 1'b0;
    chk("v1_second_vld", v1_o_vld, 1);
    chk("v1_second_sum", v1_o_sum, 16'h0002);
    chk("v1_drop", v1_o_drop, 0);

    @(posedge clk); @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
